// File: rtl/pll_rst_seq.sv
// PLL reset sequencer: pulses PLL RESET, qualifies LOCK, then releases sys_rst; retries on timeout.
// Define PLL_RST_SEQ_LOSS_CNT_EN to build the saturating lock-loss counter (otherwise it reads 0).
module pll_rst_seq #(
  parameter int unsigned PLL_RST_CYCLES = 16,
  parameter int unsigned LOCK_TIMEOUT   = 65536,
  parameter int unsigned STABLE_CYCLES  = 1024,
  parameter int unsigned MAX_RETRY      = 7
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       pll_lock_async,
  input  logic       relock_req,
  output logic       pll_reset,
  output logic       sys_rst,
  output logic       ready,
  output logic       fail,
  output logic [7:0] retry_cnt,
  output logic [7:0] lock_loss_cnt
);

  typedef enum logic [2:0] {
    ST_PLLRST   = 3'd0,
    ST_WAITLOCK = 3'd1,
    ST_STABLE   = 3'd2,
    ST_RUN      = 3'd3,
    ST_FAIL     = 3'd4
  } state_t;

  localparam logic [19:0] RST_LAST  = 20'(PLL_RST_CYCLES - 1);
  localparam logic [19:0] TMO_LAST  = 20'(LOCK_TIMEOUT - 1);
  localparam logic [19:0] STB_LAST  = 20'(STABLE_CYCLES - 1);
  localparam logic [7:0]  RETRY_MAX = 8'(MAX_RETRY);

  state_t      state_q, state_d;
  logic [19:0] cnt_q, cnt_d;
  logic [7:0]  retry_q, retry_d;
  logic [7:0]  retry_inc;
  logic        lock_meta_q, lock_s_q;
  logic        pll_reset_q, sys_rst_q, ready_q, fail_q;

  assign retry_inc = retry_q + 8'd1;

  always_comb begin
    state_d = state_q;
    retry_d = retry_q;
    case (state_q)
      ST_PLLRST: begin
        if (cnt_q == RST_LAST) state_d = ST_WAITLOCK;
      end
      ST_WAITLOCK: begin
        if (relock_req) begin
          state_d = ST_PLLRST;
          retry_d = 8'd0;
        end else if (lock_s_q) begin
          state_d = ST_STABLE;
        end else if (cnt_q == TMO_LAST) begin
          retry_d = retry_inc;
          state_d = (retry_inc == RETRY_MAX) ? ST_FAIL : ST_PLLRST;
        end
      end
      ST_STABLE: begin
        // A lock glitch only restarts qualification; it is neither a retry nor a loss.
        if (relock_req) begin
          state_d = ST_PLLRST;
          retry_d = 8'd0;
        end else if (!lock_s_q) begin
          state_d = ST_WAITLOCK;
        end else if (cnt_q == STB_LAST) begin
          state_d = ST_RUN;
          retry_d = 8'd0;
        end
      end
      ST_RUN: begin
        if (!lock_s_q || relock_req) state_d = ST_PLLRST;
      end
      ST_FAIL: begin
        if (relock_req) begin
          state_d = ST_PLLRST;
          retry_d = 8'd0;
        end
      end
      default: state_d = ST_PLLRST;
    endcase
    cnt_d = (state_d != state_q) ? 20'd0 : cnt_q + 20'd1;
  end

  // Outputs decode the next state so they switch on the same edge as the state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_PLLRST;
      cnt_q       <= 20'd0;
      retry_q     <= 8'd0;
      lock_meta_q <= 1'b0;
      lock_s_q    <= 1'b0;
      pll_reset_q <= 1'b1;
      sys_rst_q   <= 1'b1;
      ready_q     <= 1'b0;
      fail_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      retry_q     <= retry_d;
      lock_meta_q <= pll_lock_async;
      lock_s_q    <= lock_meta_q;
      pll_reset_q <= (state_d == ST_PLLRST);
      sys_rst_q   <= (state_d != ST_RUN);
      ready_q     <= (state_d == ST_RUN);
      fail_q      <= (state_d == ST_FAIL);
    end
  end

`ifdef PLL_RST_SEQ_LOSS_CNT_EN
  logic [7:0] loss_q, loss_d;
  logic       loss_hit;

  assign loss_hit = (state_q == ST_RUN) && !lock_s_q;

  always_comb begin
    loss_d = loss_q;
    if (loss_hit && (loss_q != 8'hFF)) loss_d = loss_q + 8'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) loss_q <= 8'd0;
    else     loss_q <= loss_d;
  end

  assign lock_loss_cnt = loss_q;
`else
  assign lock_loss_cnt = 8'd0;
`endif

  assign pll_reset = pll_reset_q;
  assign sys_rst   = sys_rst_q;
  assign ready     = ready_q;
  assign fail      = fail_q;
  assign retry_cnt = retry_q;

endmodule

// File: tb/tb_pll_rst_seq.sv
// Directed + random bench for pll_rst_seq; a countdown/queue reference model predicts every output each cycle.
`timescale 1ns/1ps
module tb_pll_rst_seq;
  localparam int PR = 4, TO = 100, SC = 16, MR = 3;
`ifdef PLL_RST_SEQ_LOSS_CNT_EN
  localparam bit LOSS_EN = 1'b1;
`else
  localparam bit LOSS_EN = 1'b0;
`endif
  localparam int P_RST = 0, P_WAIT = 1, P_STAB = 2, P_RUN = 3, P_FAIL = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       lock = 1'b0;
  logic       relock = 1'b0;
  logic       pll_reset, sys_rst, ready, fail;
  logic [7:0] retry_cnt, lock_loss_cnt;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  // Reference model: current phase, cycles left in it, counters, and lock samples in flight.
  int ph, left, m_retry, m_loss;
  bit lk[$];

  pll_rst_seq #(
    .PLL_RST_CYCLES(PR),
    .LOCK_TIMEOUT  (TO),
    .STABLE_CYCLES (SC),
    .MAX_RETRY     (MR)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .pll_lock_async(lock),
    .relock_req    (relock),
    .pll_reset     (pll_reset),
    .sys_rst       (sys_rst),
    .ready         (ready),
    .fail          (fail),
    .retry_cnt     (retry_cnt),
    .lock_loss_cnt (lock_loss_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s at cycle %0d: observed %0h, expected %0h", tag, cyc, obs, exp);
    end
  endtask

  task automatic enter(input int p);
    ph   = p;
    left = (p == P_RST) ? PR : (p == P_WAIT) ? TO : (p == P_STAB) ? SC : 0;
  endtask

  task automatic model_reset();
    enter(P_RST);
    m_retry = 0;
    m_loss  = 0;
    lk.delete();
    lk.push_back(1'b0);
    lk.push_back(1'b0);
  endtask

  task automatic model_edge(input bit l, input bit r);
    bit seen;
    seen = lk.pop_front();
    lk.push_back(l);
    case (ph)
      P_RST: begin
        left--;
        if (left == 0) enter(P_WAIT);
      end
      P_WAIT: begin
        if (r) begin m_retry = 0; enter(P_RST); end
        else if (seen) enter(P_STAB);
        else begin
          left--;
          if (left == 0) begin
            m_retry++;
            enter((m_retry == MR) ? P_FAIL : P_RST);
          end
        end
      end
      P_STAB: begin
        if (r) begin m_retry = 0; enter(P_RST); end
        else if (!seen) enter(P_WAIT);
        else begin
          left--;
          if (left == 0) begin m_retry = 0; enter(P_RUN); end
        end
      end
      P_RUN: begin
        if (!seen) begin
          if (m_loss < 255) m_loss++;
          enter(P_RST);
        end else if (r) enter(P_RST);
      end
      default: if (r) begin m_retry = 0; enter(P_RST); end
    endcase
  endtask

  function automatic logic [19:0] exp_vec();
    exp_vec = {ph == P_RST, ph != P_RUN, ph == P_RUN, ph == P_FAIL,
               8'(m_retry), LOSS_EN ? 8'(m_loss) : 8'd0};
  endfunction

  task automatic cyc1(input bit l, input bit r);
    lock   = l;
    relock = r;
    @(posedge clk);
    cyc++;
    if (rst) model_reset();
    else     model_edge(l, r);
    #1;
    chk("outputs", {12'd0, pll_reset, sys_rst, ready, fail, retry_cnt, lock_loss_cnt},
        {12'd0, exp_vec()});
  endtask

  task automatic wait_ready(input string tag);
    int k;
    k = 0;
    while (!ready && k < 200) begin
      cyc1(1'b1, 1'b0);
      k++;
    end
    chk(tag, {31'd0, ready}, 32'd1);
  endtask

  initial begin
    int   n, fail_at, loss0;
    logic prev_pr;
    logic [7:0] prev_rt;
    int   rises[$], falls[$], rts[$];
    bit   rl;

    model_reset();
    #1 rst = 1'b1;
    #1;
    chk("reset_vals", {12'd0, pll_reset, sys_rst, ready, fail, retry_cnt, lock_loss_cnt},
        {12'd0, 4'b1100, 8'd0, 8'd0});
    cyc1(1'b0, 1'b0);
    cyc1(1'b0, 1'b0);
    rst = 1'b0;

    // Clean lock
    n = 0;
    do begin cyc1(1'b0, 1'b0); n++; end while (pll_reset && n < 50);
    chk("init_rst_pulse", n, PR);
    repeat (9) cyc1(1'b0, 1'b0);
    n = 0;
    do begin cyc1(1'b1, 1'b0); n++; end while (sys_rst && n < 200);
    chk("lock_to_release", n, 2 + 1 + SC);
    chk("ready_up", {31'd0, ready}, 32'd1);
    chk("retry_zero", {24'd0, retry_cnt}, 32'd0);

    // Single-cycle lock loss in RUN
    loss0 = m_loss;
    cyc1(1'b0, 1'b0);
    n = 1;
    while (!sys_rst && n < 20) begin cyc1(1'b1, 1'b0); n++; end
    chk("loss_to_rst", n, 3);
    chk("loss_count", {24'd0, lock_loss_cnt}, LOSS_EN ? loss0 + 1 : 0);
    wait_ready("ready_after_loss");

    // relock_req in RUN: no loss
    loss0 = m_loss;
    cyc1(1'b1, 1'b1);
    chk("relock_run_pllrst", {31'd0, pll_reset}, 32'd1);
    chk("relock_run_noloss", {24'd0, lock_loss_cnt}, LOSS_EN ? loss0 : 0);
    wait_ready("ready_after_relock");

    // relock_req coinciding with a synchronized lock drop: loss counted
    loss0 = m_loss;
    cyc1(1'b0, 1'b0);
    cyc1(1'b1, 1'b0);
    cyc1(1'b1, 1'b1);
    chk("drop_relock_pllrst", {31'd0, pll_reset}, 32'd1);
    chk("drop_relock_loss", {24'd0, lock_loss_cnt}, LOSS_EN ? loss0 + 1 : 0);

    // 3-cycle glitch at STABLE count 8
    loss0 = m_loss;
    n = 0;
    while (!(ph == P_STAB && left == SC - 8) && n < 200) begin cyc1(1'b1, 1'b0); n++; end
    repeat (3) cyc1(1'b0, 1'b0);
    n = 0;
    do begin cyc1(1'b1, 1'b0); n++; end while (sys_rst && n < 200);
    chk("glitch_restart", n, 2 + 1 + SC);
    chk("glitch_no_retry", {24'd0, retry_cnt}, 32'd0);
    chk("glitch_no_loss", {24'd0, lock_loss_cnt}, LOSS_EN ? loss0 : 0);

    // Lock held low from RUN: loss, then timeouts until FAIL
    prev_pr = pll_reset;
    prev_rt = retry_cnt;
    n = 0;
    while (!fail && n < 1000) begin
      cyc1(1'b0, 1'b0);
      n++;
      if (pll_reset && !prev_pr) rises.push_back(cyc);
      if (!pll_reset && prev_pr) falls.push_back(cyc);
      if (retry_cnt != prev_rt) rts.push_back(int'(retry_cnt));
      prev_pr = pll_reset;
      prev_rt = retry_cnt;
    end
    fail_at = cyc;
    chk("fail_up", {31'd0, fail}, 32'd1);
    chk("fail_pll_low", {31'd0, pll_reset}, 32'd0);
    chk("fail_sys_rst", {31'd0, sys_rst}, 32'd1);
    chk("pulse_count", rises.size(), 3);
    chk("retry_steps", rts.size(), 3);
    for (int i = 0; i < rts.size(); i++) chk("retry_value", rts[i], i + 1);
    for (int i = 0; i < rises.size() && i < falls.size(); i++)
      chk("pulse_width", falls[i] - rises[i], PR);
    for (int i = 0; i + 1 < rises.size() && i < falls.size(); i++)
      chk("pulse_gap", rises[i+1] - falls[i], TO);
    if (falls.size() > 0) chk("last_gap_fail", fail_at - falls[falls.size()-1], TO);

    // relock_req out of FAIL
    cyc1(1'b0, 1'b1);
    chk("relock_fail_clear", {31'd0, fail}, 32'd0);
    chk("relock_retry_clear", {24'd0, retry_cnt}, 32'd0);
    chk("relock_pll_reset", {31'd0, pll_reset}, 32'd1);
    n = 0;
    do begin cyc1(1'b0, 1'b0); n++; end while (pll_reset && n < 50);
    chk("relock_pulse", n, PR);
    repeat (TO) cyc1(1'b0, 1'b0);
    chk("retry_one", {24'd0, retry_cnt}, 32'd1);

    // Async rst in STABLE mid-count
    n = 0;
    while (!(ph == P_STAB && left == SC - 5) && n < 300) begin cyc1(1'b1, 1'b0); n++; end
    rst = 1'b1;
    #1;
    chk("async_rst", {12'd0, pll_reset, sys_rst, ready, fail, retry_cnt, lock_loss_cnt},
        {12'd0, 4'b1100, 8'd0, 8'd0});
    model_reset();
    cyc1(1'b1, 1'b0);
    rst = 1'b0;
    wait_ready("ready_after_rst");

    // Random lock activity and relock pulses
    rl = 1'b1;
    for (int i = 0; i < 4000; i++) begin
      if (rl) rl = ($urandom_range(39) != 0);
      else    rl = ($urandom_range(59) == 0);
      cyc1(rl, $urandom_range(199) == 0);
    end

    // Saturation of the loss counter
    wait_ready("ready_before_sat");
    for (int i = 0; i < 300; i++) begin
      cyc1(1'b0, 1'b0);
      cyc1(1'b1, 1'b0);
      cyc1(1'b1, 1'b0);
      wait_ready("sat_ready");
    end
    chk("loss_sat", {24'd0, lock_loss_cnt}, LOSS_EN ? 255 : 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pll_rst_seq.md
Name: pll_rst_seq

Overview:
- Controller on the far side of the rPLL wrapper. It drives the PLL RESET pin, which the wrapper currently ties low, and consumes the PLL LOCK output.
- It sequences PLL reset, waits for lock and qualifies lock stability. It then releases a system reset to the DDR3 controller and the rest of the design.
- It detects lock loss and retries, and declares failure after repeated lock timeouts.
- It runs on the free-running board oscillator (27 MHz), never on a PLL output.

Parameters:
- PLL_RST_CYCLES, 16, cycles pll_reset is held high per attempt (1..2^20).
- LOCK_TIMEOUT, 65536, cycles allowed in WAITLOCK before the attempt is declared timed out (1..2^20).
- STABLE_CYCLES, 1024, consecutive cycles lock must stay high before sys_rst is released (1..2^20).
- MAX_RETRY, 7, number of consecutive timed-out attempts that causes FAIL (1..255).

Ports:
- clk, input, 1, free-running oscillator clock.
- rst, input, 1, asynchronous active-high reset.
- pll_lock_async, input, 1, raw PLL LOCK, asynchronous to clk.
- relock_req, input, 1, single-cycle request to re-run the full PLL reset sequence.
- pll_reset, output, 1, drives PLL RESET, active high.
- sys_rst, output, 1, active-high reset for downstream logic (clk domain).
- ready, output, 1, high while the PLL is qualified and running.
- fail, output, 1, high after MAX_RETRY consecutive lock timeouts.
- retry_cnt, output, 8, consecutive timed-out attempts in the current sequence.
- lock_loss_cnt, output, 8, saturating count of lock losses seen in RUN.

Behaviour:
- Clock and reset: one clock, clk; reset is asynchronous and active-high (rst). All flops reset asynchronously on rst.
- Reset values:
  - state = PLLRST, pll_reset = 1, sys_rst = 1.
  - ready = 0, fail = 0.
  - retry_cnt = 0, lock_loss_cnt = 0, cycle counter = 0.
  - Synchronizer flops = 0.
- Lock input: pll_lock_async passes through a 2-flop synchronizer to give lock_s, a 2-cycle latency. No other logic samples pll_lock_async.
- Counter: one 20-bit cycle counter, cleared on every state change.
- Outputs are registered Moore decodes of the next state, so they change on the same edge as the state:
  - pll_reset = (state == PLLRST).
  - sys_rst = (state != RUN).
  - ready = (state == RUN).
  - fail = (state == FAIL).
- PLLRST:
  - Counts PLL_RST_CYCLES cycles, then goes to WAITLOCK.
  - relock_req is ignored here.
- WAITLOCK:
  - If lock_s = 1, go to STABLE.
  - Else, when the counter reaches LOCK_TIMEOUT-1, increment retry_cnt. If the new value equals MAX_RETRY, go to FAIL; otherwise go to PLLRST.
  - relock_req goes to PLLRST and clears retry_cnt. relock_req has priority over the timeout.
- STABLE:
  - If lock_s = 0, go to WAITLOCK. This glitch is not counted as a retry or a loss.
  - Else, when the counter reaches STABLE_CYCLES-1, go to RUN and clear retry_cnt.
  - STABLE therefore lasts exactly STABLE_CYCLES cycles when lock stays high.
  - relock_req goes to PLLRST and clears retry_cnt. A lock drop has priority over reaching RUN on the same cycle.
- RUN:
  - If lock_s = 0, increment lock_loss_cnt (saturating at 255) and go to PLLRST. sys_rst reasserts on that same edge.
  - Else, if relock_req, go to PLLRST with no loss count.
  - If lock drop and relock_req occur together, the lock drop wins and the loss is counted.
- FAIL:
  - pll_reset stays low, sys_rst stays high.
  - Leaves only on rst, or on relock_req, which goes to PLLRST and clears retry_cnt.
- Latency: from the first clk edge sampling pll_lock_async high in WAITLOCK, sys_rst falls after 2 + 1 + STABLE_CYCLES edges.
- rst asserted mid-operation at any point gives the reset values immediately (asynchronous). The sequence restarts from PLLRST after rst releases.

Optional Feature:
- Macro: PLL_RST_SEQ_LOSS_CNT_EN.
- Defined: lock_loss_cnt is implemented as described above.
- Undefined: no counter flops are built, and lock_loss_cnt is constant 0. All other behaviour is identical.

Test Plan (PLL_RST_CYCLES=4, LOCK_TIMEOUT=100, STABLE_CYCLES=16, MAX_RETRY=3):
- Clean lock: release rst, raise lock 10 cycles after pll_reset falls -> pll_reset high for 4 cycles; sys_rst falls and ready rises 19 edges after lock is first sampled; retry_cnt = 0.
- Timeout and fail: lock held low -> three pll_reset pulses of 4 cycles, each 100 cycles apart; retry_cnt goes 1, 2, 3; fail = 1, pll_reset = 0, sys_rst = 1. Then pulse relock_req -> fail = 0, retry_cnt = 0, pll_reset high for 4 cycles.
- Glitch in STABLE: lock drops for 3 cycles at STABLE count 8 -> return to WAITLOCK; no retry, no loss counted; the full 16-cycle STABLE window restarts when lock returns.
- Lock loss in RUN: drop lock for 1 cycle -> sys_rst reasserts 3 edges later, lock_loss_cnt = 1, a new pll_reset pulse follows. 300 losses -> lock_loss_cnt saturates at 255 (0 with the macro undefined).
- relock_req in RUN -> PLLRST with lock_loss_cnt unchanged. relock_req together with a lock drop -> loss counted.
- Async rst asserted in STABLE mid-count -> pll_reset = 1, sys_rst = 1, and counters cleared before the next clk edge.
